// File: rtl/path_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : path_seq_arbiter
// Purpose  : Round-robin arbiter and sequencer for a shared launch->capture
//            register path. It grants one requester, then issues a launch
//            strobe with that requester's data. The data is held for a
//            programmable number of cycles. A capture strobe follows, and a
//            done pulse goes back to the granted requester.
// Options  : PATH_SEQ_XFER_COUNT_EN - adds a 16-bit wrapping transfer counter
//            output (xfer_count), incremented once per completed transfer.
// Revision : 1.0 - initial release
// ============================================================================
module path_seq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int HOLD_W  = 4
) (
  input  logic                      clk1,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [HOLD_W-1:0]         hold_cycles,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      launch_en,
  output logic [DATA_W-1:0]         launch_data,
  output logic                      capture_en,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
`ifdef PATH_SEQ_XFER_COUNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W1 = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_HOLD    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [DATA_W-1:0]     r_launch_data;
  logic [HOLD_W-1:0]     r_cnt;

  logic                  w_found;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W1-1:0]     w_sum;
  logic [NUM_REQ-1:0]    w_oh;
  logic [DATA_W-1:0]     w_data;

  assign gnt         = r_gnt;
  assign launch_data = r_launch_data;

  // Round-robin search: first set request bit at or above the pointer, wrapping.
  // The sum stays below 2*NUM_REQ, so a single subtraction is enough to wrap it.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + IDX_W1'(i);
      if (w_sum >= IDX_W1'(NUM_REQ)) begin
        w_sum = w_sum - IDX_W1'(NUM_REQ);
      end
      if (!w_found && req[w_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[IDX_W-1:0];
      end
    end
  end

  // Decode the winning index into a one-hot grant and select its data slice.
  always_comb begin
    w_oh   = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_oh[i] = 1'b1;
        w_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register; reset abandons any in-flight transfer.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and strobes that are decoded purely from the state.
  always_comb begin
    w_state_nxt = r_state;
    launch_en   = 1'b0;
    capture_en  = 1'b0;
    done        = '0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch_en   = 1'b1;
        w_state_nxt = (r_cnt != '0) ? S_HOLD : S_CAPTURE;
      end
      S_HOLD: begin
        if (r_cnt == HOLD_W'(1)) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture_en  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = r_gnt;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transfer datapath: latch grant, data and hold count at grant; they stay frozen until done.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_idx         <= '0;
      r_gnt         <= '0;
      r_launch_data <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx         <= w_idx;
            r_gnt         <= w_oh;
            r_launch_data <= w_data;
            r_cnt         <= hold_cycles;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PATH_SEQ_XFER_COUNT_EN
  logic [15:0] r_xfer_count;

  assign xfer_count = r_xfer_count;

  // Completed-transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_xfer_count <= '0;
    end else if (r_state == S_DONE) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/path_seq_arbiter.md
Name: path_seq_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one launch->capture register path between NUM_REQ requesters.
- Per transfer: grants one requester, issues a one-cycle launch enable with that requester's data, and holds the data stable for a programmable number of cycles to enforce a minimum launch-to-capture delay.
- Then issues a one-cycle capture enable and returns a done pulse to the granted requester.
- Sits in front of the launch (u1-style) and capture (u2-style) stages of the timing benchmark datapath.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- DATA_W, 8, width of each requester's data word.
- HOLD_W, 4, width of the hold-cycle count.

Ports:
- clk1  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  level request, one bit per requester.
- req_data  input  NUM_REQ*DATA_W  requester i's data in bits [i*DATA_W +: DATA_W].
- hold_cycles  input  HOLD_W  minimum hold cycles between launch and capture; sampled at grant.
- gnt  output  NUM_REQ  one-hot grant, held for the whole transfer.
- launch_en  output  1  one-cycle launch strobe.
- launch_data  output  DATA_W  registered data for the launch stage.
- capture_en  output  1  one-cycle capture strobe.
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, LAUNCH, HOLD, CAPTURE, DONE. State is registered; all outputs are registered or decoded from the state register only.
- Reset (async, immediate, from any state): state=IDLE, gnt=0, launch_en=0, capture_en=0, done=0, busy=0, launch_data=0, rr pointer=0, hold counter=0. A transfer in flight is discarded and no done is issued.
- IDLE:
  - If req != 0 at a clk1 edge: pick the first set bit searching from pointer upward, wrapping at NUM_REQ-1 -> 0.
  - Latch its index, load gnt one-hot, launch_data <= that requester's slice, hold counter <= hold_cycles, next state LAUNCH.
  - If req == 0: stay in IDLE.
- LAUNCH: launch_en=1 for exactly this cycle. Next state is HOLD if the counter != 0, else CAPTURE.
- HOLD: the counter decrements each cycle. When the counter == 1, the next state is CAPTURE. HOLD therefore lasts exactly hold_cycles cycles.
- CAPTURE: capture_en=1 for exactly this cycle. Next state DONE.
- DONE:
  - done[idx]=1 for one cycle; gnt cleared at the end of the cycle.
  - pointer <= (idx+1) mod NUM_REQ; next state IDLE.
- launch_data holds its value from LAUNCH until the next grant. It is never changed during HOLD or CAPTURE.
- Latency: req sampled at edge t -> launch_en during cycle t+1, capture_en during cycle t+2+H, done during t+3+H, next grant earliest at edge t+4+H (IDLE occupies one cycle between transfers).
- Boundary conditions:
  - req or req_data changing after grant is ignored; the transfer completes with the latched values.
  - hold_cycles changing mid-transfer is ignored.
  - hold_cycles = 2^HOLD_W-1 gives the maximum HOLD length; the counter never wraps.
  - A requester still asserting req after done is re-eligible, but has the lowest priority in the next arbitration.
  - Pointer wrap: after servicing requester NUM_REQ-1, the search starts at 0.
- Invariants:
  - gnt is one-hot or zero.
  - launch_en and capture_en are never high in the same cycle.
  - Exactly one done pulse per completed transfer.

Optional Feature:
- Macro: PATH_SEQ_XFER_COUNT_EN.
- Defined:
  - Adds output port xfer_count, 16 bits, reset to 0.
  - Increments by 1 in each DONE cycle and wraps from 0xFFFF to 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0010, req_data slice1=8'hA5, hold_cycles=3.
  -> gnt=4'b0010 from t+1; launch_en at t+1 with launch_data=8'hA5; capture_en at t+5; done=4'b0010 at t+6; busy low at t+7.
- Zero hold: hold_cycles=0, req=4'b0001.
  -> HOLD is skipped; capture_en one cycle after launch_en; done at t+3.
- Round-robin fairness: req=4'b1111 held constant, hold=0.
  -> grant order 0,1,2,3,0; each done pulse goes to the matching bit.
- Mid-transfer changes: during HOLD, drop req, change req_data to 8'h00, set hold_cycles=15.
  -> launch_data stays 8'hA5; capture happens at the originally scheduled cycle; done is still issued.
- Async reset during HOLD: assert rst between edges.
  -> all outputs go to 0 immediately, no done is issued; after release, a new req is granted starting from requester 0.
- With PATH_SEQ_XFER_COUNT_EN defined: 5 back-to-back transfers -> xfer_count=5. Preloading the count to 0xFFFF via transfers -> the next done wraps it to 0.
